// File: rtl/regfile_sb.sv
// Integer register file with two registered read ports, one write port and a
// write-pending scoreboard so decode can stall on RAW/WAW hazards.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hold,
    input  logic [AW-1:0]          rs1,
    input  logic [AW-1:0]          rs2,
    output logic signed [XLEN-1:0] r1,
    output logic signed [XLEN-1:0] r2,
    output logic                   r1_busy,
    output logic                   r2_busy,
    input  logic                   we,
    input  logic [AW-1:0]          wa,
    input  logic signed [XLEN-1:0] wd,
    input  logic                   alloc_en,
    input  logic [AW-1:0]          alloc_rd,
    output logic                   alloc_ok,
    input  logic                   flush,
    output logic [AW:0]            busy_cnt
);

    logic signed [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0]       busy;
    logic [NREGS-1:0]       busy_next;
    logic [AW:0]            cnt_next;
    logic signed [XLEN-1:0] rd1_next;
    logic signed [XLEN-1:0] rd2_next;
    logic                   rb1_next;
    logic                   rb2_next;

    // A new producer issued on the same edge as an older writeback owns the register.
    always_comb begin
        busy_next = busy;
        for (int i = 1; i < NREGS; i++) begin
            if (flush)
                busy_next[i] = 1'b0;
            else if (alloc_en && alloc_rd == AW'(i))
                busy_next[i] = 1'b1;
            else if (we && wa == AW'(i))
                busy_next[i] = 1'b0;
        end
        busy_next[0] = 1'b0;
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NREGS; i++)
            cnt_next = cnt_next + (AW+1)'(busy_next[i]);
    end

    assign alloc_ok = (alloc_rd == '0) || !busy[alloc_rd];

    always_comb begin
        rd1_next = regs[rs1];
        rd2_next = regs[rs2];
        rb1_next = busy[rs1];
        rb2_next = busy[rs2];
        if (BYPASS) begin
            if (we && wa == rs1 && rs1 != '0)
                rd1_next = wd;
            if (we && wa == rs2 && rs2 != '0)
                rd2_next = wd;
            rb1_next = busy_next[rs1];
            rb2_next = busy_next[rs2];
        end
    end

    // Entry 0 is never written, so it reads as zero from reset onwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1      <= '0;
            r2      <= '0;
            r1_busy <= 1'b0;
            r2_busy <= 1'b0;
        end else if (!hold) begin
            r1      <= rd1_next;
            r2      <= rd2_next;
            r1_busy <= rb1_next;
            r2_busy <= rb2_next;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: write-first and read-before-write instances driven in
// parallel, checked against an architectural model plus literal expectations.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold = 1'b0;
    logic        we = 1'b0;
    logic        alloc_en = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [4:0]  wa = '0;
    logic [4:0]  alloc_rd = '0;
    logic [31:0] wd = '0;

    logic [31:0] byp_r1, byp_r2, rbw_r1, rbw_r2;
    logic        byp_b1, byp_b2, rbw_b1, rbw_b2, byp_ok, rbw_ok;
    logic [5:0]  byp_cnt, rbw_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .rs1(rs1), .rs2(rs2),
        .r1(byp_r1), .r2(byp_r2), .r1_busy(byp_b1), .r2_busy(byp_b2),
        .we(we), .wa(wa), .wd(wd), .alloc_en(alloc_en), .alloc_rd(alloc_rd),
        .alloc_ok(byp_ok), .flush(flush), .busy_cnt(byp_cnt)
    );

    regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) dut_rbw (
        .clk(clk), .rst_n(rst_n), .hold(hold), .rs1(rs1), .rs2(rs2),
        .r1(rbw_r1), .r2(rbw_r2), .r1_busy(rbw_b1), .r2_busy(rbw_b2),
        .we(we), .wa(wa), .wd(wd), .alloc_en(alloc_en), .alloc_rd(alloc_rd),
        .alloc_ok(rbw_ok), .flush(flush), .busy_cnt(rbw_cnt)
    );

    // Architectural model: register contents plus the set of pending destinations.
    logic [31:0] m_regs [32];
    logic [31:0] n_regs [32];
    logic [31:0] m_busy, n_busy;
    logic [31:0] eb_r1, eb_r2, e0_r1, e0_r2;
    logic        eb_b1, eb_b2, e0_b1, e0_b2;
    logic [5:0]  e_cnt;

    always_comb begin
        n_regs = m_regs;
        n_busy = m_busy;
        if (we && wa != 5'd0)
            n_regs[wa] = wd;
        if (flush) begin
            n_busy = '0;
        end else begin
            if (we && wa != 5'd0)
                n_busy[wa] = 1'b0;
            if (alloc_en && alloc_rd != 5'd0)
                n_busy[alloc_rd] = 1'b1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                m_regs[i] <= '0;
            m_busy <= '0;
            eb_r1 <= '0; eb_r2 <= '0; e0_r1 <= '0; e0_r2 <= '0;
            eb_b1 <= 1'b0; eb_b2 <= 1'b0; e0_b1 <= 1'b0; e0_b2 <= 1'b0;
            e_cnt <= '0;
        end else begin
            m_regs <= n_regs;
            m_busy <= n_busy;
            e_cnt  <= 6'($countones(n_busy));
            if (!hold) begin
                eb_r1 <= n_regs[rs1];  eb_r2 <= n_regs[rs2];
                eb_b1 <= n_busy[rs1];  eb_b2 <= n_busy[rs2];
                e0_r1 <= m_regs[rs1];  e0_r2 <= m_regs[rs2];
                e0_b1 <= m_busy[rs1];  e0_b2 <= m_busy[rs2];
            end
        end
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check_output("byp_r1", 64'(byp_r1), 64'(eb_r1));
            check_output("byp_r2", 64'(byp_r2), 64'(eb_r2));
            check_output("byp_b1", 64'(byp_b1), 64'(eb_b1));
            check_output("byp_b2", 64'(byp_b2), 64'(eb_b2));
            check_output("byp_cnt", 64'(byp_cnt), 64'(e_cnt));
            check_output("rbw_r1", 64'(rbw_r1), 64'(e0_r1));
            check_output("rbw_r2", 64'(rbw_r2), 64'(e0_r2));
            check_output("rbw_b1", 64'(rbw_b1), 64'(e0_b1));
            check_output("rbw_b2", 64'(rbw_b2), 64'(e0_b2));
            check_output("rbw_cnt", 64'(rbw_cnt), 64'(e_cnt));
            check_output("alloc_ok", 64'(byp_ok), 64'((alloc_rd == 5'd0) || !m_busy[alloc_rd]));
            check_output("alloc_ok_rbw", 64'(rbw_ok), 64'((alloc_rd == 5'd0) || !m_busy[alloc_rd]));
        end
    end

    // Drives one edge worth of inputs, then returns 1 time unit after that edge
    // with the one-shot controls cleared.
    task automatic apply_stimulus(input logic we_v, input logic [4:0] wa_v, input logic [31:0] wd_v,
                                  input logic al_v, input logic [4:0] ar_v, input logic fl_v,
                                  input logic hold_v, input logic [4:0] rs1_v, input logic [4:0] rs2_v);
        we = we_v; wa = wa_v; wd = wd_v;
        alloc_en = al_v; alloc_rd = ar_v; flush = fl_v;
        hold = hold_v; rs1 = rs1_v; rs2 = rs2_v;
        @(posedge clk);
        #1;
        we = 1'b0; alloc_en = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #12;
        rst_n = 1'b1;
        cmp_en = 1'b1;

        for (int i = 0; i < 32; i++) begin
            apply_stimulus(0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
            check_output("reset_r1", 64'(byp_r1), 64'd0);
            check_output("reset_r2", 64'(rbw_r2), 64'd0);
        end
        check_output("reset_cnt", 64'(byp_cnt), 64'd0);
        check_output("reset_b1", 64'(byp_b1), 64'd0);

        apply_stimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 0);
        check_output("bypass_r1", 64'(byp_r1), 64'hDEADBEEF);
        check_output("rbw_old_r1", 64'(rbw_r1), 64'd0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 5, 0);
        check_output("rbw_new_r1", 64'(rbw_r1), 64'hDEADBEEF);

        apply_stimulus(1, 0, 32'h1234, 1, 0, 0, 0, 0, 0);
        check_output("x0_r1", 64'(byp_r1), 64'd0);
        check_output("x0_b1", 64'(byp_b1), 64'd0);
        check_output("x0_ok", 64'(byp_ok), 64'd1);
        check_output("x0_cnt", 64'(byp_cnt), 64'd0);

        apply_stimulus(0, 0, 0, 1, 7, 0, 0, 7, 0);
        check_output("alloc7_b1", 64'(byp_b1), 64'd1);
        check_output("alloc7_cnt", 64'(byp_cnt), 64'd1);
        check_output("alloc7_ok", 64'(byp_ok), 64'd0);

        apply_stimulus(1, 7, 32'd42, 0, 7, 0, 0, 7, 0);
        check_output("wb7_r1", 64'(byp_r1), 64'd42);
        check_output("wb7_b1", 64'(byp_b1), 64'd0);
        check_output("wb7_cnt", 64'(byp_cnt), 64'd0);

        apply_stimulus(1, 7, 32'd99, 1, 7, 0, 0, 7, 0);
        check_output("coll_r1", 64'(byp_r1), 64'd99);
        check_output("coll_b1", 64'(byp_b1), 64'd1);
        check_output("coll_cnt", 64'(byp_cnt), 64'd1);
        apply_stimulus(1, 7, 32'd7, 0, 0, 0, 0, 7, 0);

        apply_stimulus(0, 0, 0, 1, 3, 0, 0, 10, 0);
        apply_stimulus(0, 0, 0, 1, 4, 0, 0, 10, 0);
        apply_stimulus(0, 0, 0, 1, 9, 0, 0, 10, 0);
        check_output("pre_flush_cnt", 64'(byp_cnt), 64'd3);
        apply_stimulus(0, 0, 0, 1, 10, 1, 0, 10, 0);
        check_output("flush_cnt", 64'(byp_cnt), 64'd0);
        check_output("flush_b1", 64'(byp_b1), 64'd0);

        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 5, 0);
        check_output("prehold_r1", 64'(byp_r1), 64'hDEADBEEF);
        apply_stimulus(1, 5, 32'h55, 0, 0, 0, 1, 7, 0);
        check_output("hold_r1", 64'(byp_r1), 64'hDEADBEEF);
        check_output("hold_rbw_r1", 64'(rbw_r1), 64'hDEADBEEF);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 5, 0);
        check_output("posthold_r1", 64'(byp_r1), 64'h55);
        check_output("posthold_rbw_r1", 64'(rbw_r1), 64'h55);

        apply_stimulus(0, 0, 0, 1, 3, 0, 0, 5, 5);
        check_output("prerst_cnt", 64'(byp_cnt), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("arst_r1", 64'(byp_r1), 64'd0);
        check_output("arst_r2", 64'(byp_r2), 64'd0);
        check_output("arst_cnt", 64'(byp_cnt), 64'd0);
        check_output("arst_rbw_r1", 64'(rbw_r1), 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 5, 3);
        check_output("postrst_r1", 64'(byp_r1), 64'd0);
        check_output("postrst_b2", 64'(byp_b2), 64'd0);

        for (int k = 0; k < 40; k++) begin
            apply_stimulus(k % 3 != 0, 5'((k * 7) % 32), (32'(k) * 32'h01010101) ^ 32'hA5A5,
                           k % 2 == 1, 5'((k * 5) % 32), k == 25, k % 11 == 4,
                           5'((k * 7) % 32), 5'((k * 5) % 32));
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 2);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 3, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
